joiner: RTL and testbench

- Bit-serial receiver. It reassembles the MSB-first byte stream produced by the team's serializer (`splitter`) back into up to four 8-bit registers.
- Slot selection uses the same sw1..sw4 switch set as the serializer. The frame is gated by the same `holder` enable.
- Sits at the far end of the serial link. Its outputs feed compare/display logic.

---
 rtl/joiner.sv | 162 ++++++++++++++++
 tb/tb_joiner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/joiner.sv
// Bit-serial MSB-first receiver: samples din mid-bit and reassembles up to four
// bytes into the slots selected by {sw4..sw1}, which are latched when a frame starts.
module joiner #(
  parameter int BIT_CYCLES = 256
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       din,
  input  logic       holder,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       sw4,
  output logic [7:0] byte1,
  output logic [7:0] byte2,
  output logic [7:0] byte3,
  output logic [7:0] byte4,
  output logic [3:0] valid,
  output logic [3:0] bit_cnt,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam int PW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [PW-1:0] SAMPLE_PH = PW'(BIT_CYCLES/2 - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_holder_q;
  logic [3:0]          r_mask, w_mask_nxt;
  logic [1:0]          r_slot, w_slot_nxt;
  logic [PW-1:0]       r_phase, w_phase_nxt;
  logic [7:0]          r_shift, w_shift_nxt;
  logic [3:0][7:0]     r_bytes, w_bytes_nxt;
  logic [3:0]          r_valid, w_valid_nxt;
  logic [3:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_aborted, w_aborted_nxt;

  logic                w_start;
  logic [3:0]          w_mask_in;
  logic [3:0]          w_above;
  logic [2:0]          w_first, w_next;

  // {found, index} of the lowest set bit
  function automatic logic [2:0] first_set(input logic [3:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) r = {1'b1, 2'(i)};
    return r;
  endfunction

  assign w_start   = holder & ~r_holder_q;
  assign w_mask_in = {sw4, sw3, sw2, sw1};
  assign w_above   = 4'b1110 << r_slot;
  assign w_first   = first_set(w_mask_in);
  assign w_next    = first_set(r_mask & w_above);

  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_slot_nxt    = r_slot;
    w_phase_nxt   = r_phase;
    w_shift_nxt   = r_shift;
    w_bytes_nxt   = r_bytes;
    w_valid_nxt   = r_valid;
    w_bit_cnt_nxt = r_bit_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start && (w_mask_in != 4'd0)) begin
          w_mask_nxt    = w_mask_in;
          w_valid_nxt   = 4'd0;
          w_slot_nxt    = w_first[1:0];
          w_phase_nxt   = '0;
          w_bit_cnt_nxt = 4'd8;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_RX;
        end
      end
      S_RX: begin
        // holder loss wins over a sample or commit landing on the same edge
        if (!holder) begin
          w_aborted_nxt = 1'b1;
          w_busy_nxt    = 1'b0;
          w_bit_cnt_nxt = 4'd0;
          w_shift_nxt   = 8'd0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_phase_nxt = (r_phase == LAST_PH) ? '0 : r_phase + PW'(1);
          if (r_phase == SAMPLE_PH) begin
            w_shift_nxt   = {r_shift[6:0], din};
            w_bit_cnt_nxt = r_bit_cnt - 4'd1;
          end
          if ((r_phase == LAST_PH) && (r_bit_cnt == 4'd0)) begin
            w_bytes_nxt[r_slot] = r_shift;
            w_valid_nxt[r_slot] = 1'b1;
            if (w_next[2]) begin
              w_slot_nxt    = w_next[1:0];
              w_bit_cnt_nxt = 4'd8;
            end else begin
              w_busy_nxt    = 1'b0;
              w_bit_cnt_nxt = 4'd0;
              w_done_nxt    = 1'b1;
              w_state_nxt   = S_DONE;
            end
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_holder_q <= 1'b0;
      r_mask     <= '0;
      r_slot     <= '0;
      r_phase    <= '0;
      r_shift    <= '0;
      r_bytes    <= '0;
      r_valid    <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_holder_q <= holder;
      r_mask     <= w_mask_nxt;
      r_slot     <= w_slot_nxt;
      r_phase    <= w_phase_nxt;
      r_shift    <= w_shift_nxt;
      r_bytes    <= w_bytes_nxt;
      r_valid    <= w_valid_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_aborted  <= w_aborted_nxt;
    end
  end

  assign byte1   = r_bytes[0];
  assign byte2   = r_bytes[1];
  assign byte3   = r_bytes[2];
  assign byte4   = r_bytes[3];
  assign valid   = r_valid;
  assign bit_cnt = r_bit_cnt;
  assign busy    = r_busy;
  assign done    = r_done;
  assign aborted = r_aborted;

endmodule

// File: tb/tb_joiner.sv
// Bench for joiner: two instances (BIT_CYCLES 8 and 256) checked every cycle against
// a timing-formula model, plus hand-computed literal expectations per scenario.
module tb_joiner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       hold[2];
  logic       din_s[2];
  logic [3:0] sw_s[2];
  logic [7:0] b1_o[2], b2_o[2], b3_o[2], b4_o[2];
  logic [3:0] val_o[2], bc_o[2];
  logic       busy_o[2], done_o[2], ab_o[2];

  int ntests = 0, nfail = 0, cyc = 0;

  always #5 clk = ~clk;

  joiner #(.BIT_CYCLES(8)) u_j8 (
    .sysclk(clk), .reset(rst), .din(din_s[0]), .holder(hold[0]),
    .sw1(sw_s[0][0]), .sw2(sw_s[0][1]), .sw3(sw_s[0][2]), .sw4(sw_s[0][3]),
    .byte1(b1_o[0]), .byte2(b2_o[0]), .byte3(b3_o[0]), .byte4(b4_o[0]),
    .valid(val_o[0]), .bit_cnt(bc_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .aborted(ab_o[0]));

  joiner #(.BIT_CYCLES(256)) u_j256 (
    .sysclk(clk), .reset(rst), .din(din_s[1]), .holder(hold[1]),
    .sw1(sw_s[1][0]), .sw2(sw_s[1][1]), .sw3(sw_s[1][2]), .sw4(sw_s[1][3]),
    .byte1(b1_o[1]), .byte2(b2_o[1]), .byte3(b3_o[1]), .byte4(b4_o[1]),
    .valid(val_o[1]), .bit_cnt(bc_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .aborted(ab_o[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model: expected outputs from the frame timing rules ----------------
  logic [7:0] x_byte[2][4];
  logic [3:0] x_valid[2], x_bcnt[2], x_mask[2];
  logic [7:0] x_acc[2];
  logic       x_busy[2], x_done[2], x_abort[2], x_hq[2];
  int         x_mode[2], x_e[2];   // mode 0 idle, 1 receiving, 2 done cycle

  function automatic int nth_slot(input logic [3:0] m, input int k);
    int c = 0;
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        if (c == k) return i;
        c++;
      end
    return 0;
  endfunction

  task automatic model_clear();
    for (int ch = 0; ch < 2; ch++) begin
      for (int s = 0; s < 4; s++) x_byte[ch][s] = 8'd0;
      x_valid[ch] = 0; x_bcnt[ch] = 0; x_mask[ch] = 0; x_acc[ch] = 0;
      x_busy[ch] = 0; x_done[ch] = 0; x_abort[ch] = 0; x_hq[ch] = 0;
      x_mode[ch] = 0; x_e[ch] = 0;
    end
  endtask

  initial begin
    int bc, kk, s;
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else begin
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
          bc = (ch == 0) ? 8 : 256;
          x_done[ch] = 0; x_abort[ch] = 0;
          if (x_mode[ch] == 2) x_mode[ch] = 0;
          else if (x_mode[ch] == 0) begin
            if (hold[ch] && !x_hq[ch] && sw_s[ch] != 4'd0) begin
              x_mode[ch] = 1; x_e[ch] = 0; x_mask[ch] = sw_s[ch];
              x_valid[ch] = 0; x_busy[ch] = 1; x_bcnt[ch] = 8;
            end
          end else begin
            x_e[ch]++;
            if (!hold[ch]) begin
              x_mode[ch] = 0; x_busy[ch] = 0; x_bcnt[ch] = 0; x_abort[ch] = 1;
            end else begin
              if (x_e[ch] >= bc/2 && (x_e[ch] - bc/2) % bc == 0) begin
                x_acc[ch] = {x_acc[ch][6:0], din_s[ch]};
                x_bcnt[ch] = x_bcnt[ch] - 4'd1;
              end
              if (x_e[ch] % (8*bc) == 0) begin
                kk = x_e[ch] / (8*bc) - 1;
                s = nth_slot(x_mask[ch], kk);
                x_byte[ch][s] = x_acc[ch];
                x_valid[ch][s] = 1'b1;
                if (kk + 1 == $countones(x_mask[ch])) begin
                  x_mode[ch] = 2; x_busy[ch] = 0; x_bcnt[ch] = 0; x_done[ch] = 1;
                end else x_bcnt[ch] = 8;
              end
            end
          end
          x_hq[ch] = hold[ch];
        end
      end
    end
  end

  // ---------------- compare + event monitors ----------------
  int busy_cnt[2], done_cnt[2], ab_cnt[2], last_done[2];

  initial begin
    logic [42:0] act, exp;
    for (int ch = 0; ch < 2; ch++) begin
      busy_cnt[ch] = 0; done_cnt[ch] = 0; ab_cnt[ch] = 0; last_done[ch] = -1;
    end
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        act = {b4_o[ch], b3_o[ch], b2_o[ch], b1_o[ch], val_o[ch], bc_o[ch],
               busy_o[ch], done_o[ch], ab_o[ch]};
        exp = {x_byte[ch][3], x_byte[ch][2], x_byte[ch][1], x_byte[ch][0], x_valid[ch],
               x_bcnt[ch], x_busy[ch], x_done[ch], x_abort[ch]};
        chk($sformatf("ch%0d cycle %0d outputs", ch, cyc), 64'(act), 64'(exp));
        if (busy_o[ch]) busy_cnt[ch]++;
        if (ab_o[ch]) ab_cnt[ch]++;
        if (done_o[ch]) begin
          done_cnt[ch]++;
          last_done[ch] = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int t0_r[2], busy0, done0, ab0;

  task automatic frame(input int ch, input logic [3:0] mask, input logic [31:0] data,
                       input int nbits, input bit abort_it, input bit tog_sw1);
    int bc = (ch == 0) ? 8 : 256;
    @(negedge clk);
    busy0 = busy_cnt[ch]; done0 = done_cnt[ch]; ab0 = ab_cnt[ch];
    sw_s[ch] = mask;
    hold[ch] = 1'b1;
    t0_r[ch] = cyc + 1;
    for (int m = 0; m < nbits; m++) begin
      din_s[ch] = data[31-m];
      if (tog_sw1 && m == 5) sw_s[ch][0] = ~sw_s[ch][0];
      repeat (bc) @(negedge clk);
    end
    if (!abort_it) repeat (4) @(negedge clk);
    hold[ch] = 1'b0;
    din_s[ch] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    for (int ch = 0; ch < 2; ch++) begin
      hold[ch] = 0; din_s[ch] = 0; sw_s[ch] = 0; t0_r[ch] = 0;
    end
    busy0 = 0; done0 = 0; ab0 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of bit 3 of byte1
    pat = 8'h55;
    sw_s[0] = 4'b0001;
    hold[0] = 1'b1;
    for (int m = 0; m < 3; m++) begin
      din_s[0] = pat[7-m];
      repeat (8) @(negedge clk);
    end
    din_s[0] = pat[4];
    repeat (3) @(negedge clk);
    chk("pre-reset busy", 64'(busy_o[0]), 64'd1);
    chk("pre-reset bit_cnt", 64'(bc_o[0]), 64'd5);
    #1 rst = 1'b1;
    #1 chk("reset clears outputs",
           64'({b4_o[0], b3_o[0], b2_o[0], b1_o[0], val_o[0], bc_o[0], busy_o[0], done_o[0], ab_o[0]}),
           64'd0);
    hold[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single slot, 0x55
    frame(0, 4'b0001, {8'h55, 24'h0}, 8, 1'b0, 1'b0);
    chk("sw1 byte1", 64'(b1_o[0]), 64'h55);
    chk("sw1 valid", 64'(val_o[0]), 64'h1);
    chk("sw1 byte2..4", 64'({b4_o[0], b3_o[0], b2_o[0]}), 64'h0);
    chk("sw1 done edge", 64'(last_done[0]), 64'(t0_r[0] + 64));
    chk("sw1 done count", 64'(done_cnt[0] - done0), 64'd1);

    // all slots
    frame(0, 4'b1111, 32'h55AA3CC3, 32, 1'b0, 1'b0);
    chk("all bytes", 64'({b4_o[0], b3_o[0], b2_o[0], b1_o[0]}), 64'hC33CAA55);
    chk("all valid", 64'(val_o[0]), 64'hF);
    chk("all done edge", 64'(last_done[0]), 64'(t0_r[0] + 256));
    chk("all busy cycles", 64'(busy_cnt[0] - busy0), 64'd256);

    // sw1+sw2, holder dropped after 12 bits
    frame(0, 4'b0011, {8'h96, 8'h0F, 16'h0}, 12, 1'b1, 1'b0);
    chk("abort byte1", 64'(b1_o[0]), 64'h96);
    chk("abort byte2 kept", 64'(b2_o[0]), 64'hAA);
    chk("abort valid", 64'(val_o[0]), 64'h1);
    chk("abort pulse count", 64'(ab_cnt[0] - ab0), 64'd1);
    chk("abort no done", 64'(done_cnt[0] - done0), 64'd0);

    // empty mask
    frame(0, 4'b0000, 32'h0, 0, 1'b0, 1'b0);
    chk("mask0 busy cycles", 64'(busy_cnt[0] - busy0), 64'd0);
    chk("mask0 no done/abort", 64'((done_cnt[0] - done0) + (ab_cnt[0] - ab0)), 64'd0);
    chk("mask0 regs kept", 64'({b4_o[0], b3_o[0], b2_o[0], b1_o[0], val_o[0]}), 64'hC33CAA961);

    // BIT_CYCLES=256, sw2+sw4, sw1 toggled mid-frame
    frame(1, 4'b1010, {8'h3C, 8'hC3, 16'h0}, 16, 1'b0, 1'b1);
    chk("bc256 byte2", 64'(b2_o[1]), 64'h3C);
    chk("bc256 byte4", 64'(b4_o[1]), 64'hC3);
    chk("bc256 byte1/3", 64'({b3_o[1], b1_o[1]}), 64'h0);
    chk("bc256 valid", 64'(val_o[1]), 64'hA);
    chk("bc256 done edge", 64'(last_done[1]), 64'(t0_r[1] + 4096));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
